// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory stage placed right after the EX/MEM pipeline register.
// Executes loads/stores against an internal word-organised data memory and
// returns one completion (data + PC tag + error flag) per accepted request.
// Non-memory ops pass their EX result (addr) straight through.
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   req_valid/ready    request handshake from EX/MEM
//   op_read, op_write  load / store flags (both set = illegal)
//   size               0=byte 1=half 2=word 3=reserved
//   load_unsigned      zero-extend (1) or sign-extend (0) narrow loads
//   addr, wdata, pc_in effective address / EX result, store data, PC tag
//   resp_valid/ready   completion handshake toward writeback/ROB
//   resp_data, resp_pc, resp_err  completion payload
//
// Optional feature macro LSU_PERF_CNT_EN adds load_count / store_count outputs
// counting accepted non-error loads and stores.
module mem_stage_lsu #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              op_read,
  input  logic              op_write,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       pc_in,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [31:0]       resp_pc,
  output logic              resp_err
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]       load_count,
  output logic [31:0]       store_count
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, LOAD_RD, RESP} state_t;

  state_t           state;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic             is_mem;
  logic             misaligned;
  logic             req_err;
  logic             do_store;
  logic             do_load;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      wword;

  // Load context carried from the accept edge into LOAD_RD
  logic [31:0]      rd_word_p1;
  logic [1:0]       ld_size_p1;
  logic [1:0]       ld_lane_p1;
  logic             ld_uns_p1;

  // Pick the addressed byte/half out of a memory word and extend to 32 bits.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  lane,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      2'd0:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Reset gates accept so a request presented during reset never writes memory.
  assign accept   = rstn && req_valid && req_ready;
  assign is_mem   = op_read || op_write;
  assign idx      = addr[IDX_W+1:2];
  assign req_err  = (op_read && op_write) || (is_mem && misaligned);
  assign do_store = accept && op_write && !req_err;
  assign do_load  = accept && op_read && !req_err;

  always_comb begin
    misaligned = 1'b0;
    be         = 4'b1111;
    wword      = wdata;
    case (size)
      2'd0: begin
        be    = 4'b0001 << addr[1:0];
        wword = {4{wdata[7:0]}};
      end
      2'd1: begin
        misaligned = addr[0];
        be         = addr[1] ? 4'b1100 : 4'b0011;
        wword      = {2{wdata[15:0]}};
      end
      2'd2:    misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // ---- stage p0 -> p1: memory write / synchronous read at the accept edge ----
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
    if (do_load) rd_word_p1 <= mem[idx];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_pc    <= '0;
      resp_err   <= 1'b0;
      ld_size_p1 <= '0;
      ld_lane_p1 <= '0;
      ld_uns_p1  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            resp_pc   <= pc_in;
            resp_err  <= 1'b0;
            if (req_err) begin
              resp_err   <= 1'b1;
              resp_data  <= '0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (op_read) begin
              ld_size_p1 <= size;
              ld_lane_p1 <= addr[1:0];
              ld_uns_p1  <= load_unsigned;
              state      <= LOAD_RD;
            end else begin
              resp_data  <= op_write ? 32'd0 : 32'(addr);
              resp_valid <= 1'b1;
              state      <= RESP;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        // ---- stage p1 -> p2: lane extract and extend ----
        LOAD_RD: begin
          resp_data  <= extract_load(rd_word_p1, ld_size_p1, ld_lane_p1, ld_uns_p1);
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      load_count  <= '0;
      store_count <= '0;
    end else begin
      if (do_load)  load_count  <= load_count + 32'd1;
      if (do_store) store_count <= store_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu. A byte-addressed reference memory and a
// transaction-level response rule produce the expected completion of every
// request; a single negedge process compares DUT outputs every cycle.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        op_read = 1'b0;
  logic        op_write = 1'b0;
  logic [1:0]  size = 2'd0;
  logic        load_unsigned = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] pc_in = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [31:0] resp_pc;
  logic        resp_err;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] load_count;
  logic [31:0] store_count;
`endif

  mem_stage_lsu #(.DEPTH_WORDS(256), .ADDR_W(32)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .op_read(op_read), .op_write(op_write), .size(size),
    .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata), .pc_in(pc_in),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_pc(resp_pc), .resp_err(resp_err)
`ifdef LSU_PERF_CNT_EN
    , .load_count(load_count), .store_count(store_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected observable state, updated by the driver just after each edge
  logic        chk_en = 1'b0;
  logic        exp_rst = 1'b0;
  logic        exp_ready = 1'b0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_data = '0;
  logic [31:0] exp_pc = '0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_lc = '0;
  logic [31:0] exp_sc = '0;

  logic [7:0]  mmem [1024];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, ex, $time);
    end
  endtask

  // Reference behaviour: byte memory wrapping at 1 KiB, little-endian.
  task automatic model(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] d, output logic e);
    int     n;
    longint v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e = (rd && wr) || ((rd || wr) && (sz == 2'd3 || (a % n) != 0));
    d = '0;
    if (e) begin
      d = '0;
    end else if (wr) begin
      for (int i = 0; i < n; i++) mmem[int'((a + 32'(i)) & 32'h3FF)] = wd[8*i +: 8];
    end else if (rd) begin
      v = 0;
      for (int i = 0; i < n; i++)
        v = v | (longint'(mmem[int'((a + 32'(i)) & 32'h3FF)]) << (8 * i));
      if (!uns && v[8*n-1]) v = v - (64'sd1 << (8 * n));
      d = v[31:0];
    end else begin
      d = a;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_valid});
      if (exp_valid || exp_rst) begin
        chk("resp_data", resp_data, exp_rst ? 32'd0 : exp_data);
        chk("resp_pc", resp_pc, exp_rst ? 32'd0 : exp_pc);
        chk("resp_err", {31'd0, resp_err}, exp_rst ? 32'd0 : {31'd0, exp_err});
      end
`ifdef LSU_PERF_CNT_EN
      chk("load_count", load_count, exp_lc);
      chk("store_count", store_count, exp_sc);
`endif
    end
  end

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1; exp_rst = 1'b1; exp_valid = 1'b0; exp_ready = 1'b0;
    exp_lc = '0; exp_sc = '0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    exp_rst = 1'b0; exp_ready = 1'b1;
  endtask

  // One request, held until accepted (DUT is idle at call), then the response
  // is drained after `stall` cycles of backpressure. lit/lit_err pin the model.
  task automatic txn(input logic rd, input logic wr, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] pc, input int stall,
                     input logic [31:0] lit, input logic lit_err);
    logic [31:0] md;
    logic        me;
    req_valid = 1'b1; op_read = rd; op_write = wr; size = sz;
    load_unsigned = uns; addr = a; wdata = wd; pc_in = pc;
    model(rd, wr, sz, uns, a, wd, md, me);
    chk("model_data", md, lit);
    chk("model_err", {31'd0, me}, {31'd0, lit_err});
    @(posedge clk); #1;
    req_valid = 1'b0; addr = 32'hFFFF_FFFF; pc_in = '0; wdata = '0;
    exp_ready = 1'b0; exp_data = md; exp_err = me; exp_pc = pc;
    if (!me && rd) exp_lc = exp_lc + 1;
    if (!me && wr) exp_sc = exp_sc + 1;
    if (rd && !me) begin
      exp_valid = 1'b0;
      @(posedge clk); #1;
    end
    exp_valid = 1'b1;
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; exp_valid = 1'b0; exp_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mmem[i] = 8'h00;
    do_reset();

    // Word store then load
    txn(0, 1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 32'h100, 0, 32'h0, 0);
    txn(1, 0, 2'd2, 0, 32'h10, 32'h0, 32'h104, 0, 32'hDEAD_BEEF, 0);

    // Byte/half extension
    txn(0, 1, 2'd2, 0, 32'h20, 32'h80FF_7F01, 32'h108, 0, 32'h0, 0);
    txn(1, 0, 2'd0, 0, 32'h22, 32'h0, 32'h10C, 0, 32'hFFFF_FFFF, 0);
    txn(1, 0, 2'd0, 1, 32'h22, 32'h0, 32'h110, 0, 32'h0000_00FF, 0);
    txn(1, 0, 2'd1, 0, 32'h22, 32'h0, 32'h114, 0, 32'hFFFF_80FF, 0);
    txn(1, 0, 2'd0, 0, 32'h20, 32'h0, 32'h118, 0, 32'h0000_0001, 0);
    txn(1, 0, 2'd1, 1, 32'h20, 32'h0, 32'h11C, 1, 32'h0000_7F01, 0);

    // Errors leave memory untouched
    txn(1, 0, 2'd1, 0, 32'h21, 32'h0, 32'h120, 0, 32'h0, 1);
    txn(1, 1, 2'd2, 0, 32'h20, 32'h1111_1111, 32'h124, 0, 32'h0, 1);
    txn(0, 1, 2'd2, 0, 32'h22, 32'h2222_2222, 32'h128, 0, 32'h0, 1);
    txn(0, 1, 2'd3, 0, 32'h20, 32'h3333_3333, 32'h12C, 0, 32'h0, 1);
    txn(1, 0, 2'd2, 0, 32'h20, 32'h0, 32'h130, 0, 32'h80FF_7F01, 0);

    // Passthrough with backpressure
    txn(0, 0, 2'd0, 0, 32'h1234_5678, 32'h0, 32'h134, 5, 32'h1234_5678, 0);
    txn(0, 0, 2'd3, 0, 32'h0000_0003, 32'h0, 32'h138, 0, 32'h0000_0003, 0);

    // Address wrap
    txn(0, 1, 2'd2, 0, 32'h400, 32'hCAFE_F00D, 32'h13C, 0, 32'h0, 0);
    txn(1, 0, 2'd2, 0, 32'h0, 32'h0, 32'h140, 2, 32'hCAFE_F00D, 0);

    // Reset while a load sits in LOAD_RD
    req_valid = 1'b1; op_read = 1'b1; op_write = 1'b0; size = 2'd2;
    load_unsigned = 1'b0; addr = 32'h10; pc_in = 32'h200;
    @(posedge clk); #1;
    req_valid = 1'b0; op_read = 1'b0;
    exp_ready = 1'b0; exp_valid = 1'b0; exp_lc = exp_lc + 1;
    rstn = 1'b0;
    @(posedge clk); #1;
    exp_rst = 1'b1; exp_lc = '0; exp_sc = '0;
    rstn = 1'b1;
    @(posedge clk); #1;
    exp_rst = 1'b0; exp_ready = 1'b1;
    @(posedge clk); #1;

    // Memory survives reset; one store + one load for the counters
    txn(1, 0, 2'd2, 0, 32'h10, 32'h0, 32'h204, 0, 32'hDEAD_BEEF, 0);
    txn(0, 1, 2'd2, 0, 32'h30, 32'h0BAD_C0DE, 32'h208, 0, 32'h0, 0);
`ifdef LSU_PERF_CNT_EN
    chk("load_count_lit", load_count, 32'd1);
    chk("store_count_lit", store_count, 32'd1);
`endif

    // Narrow stores into lanes
    txn(0, 1, 2'd0, 0, 32'h31, 32'h0000_00AB, 32'h20C, 0, 32'h0, 0);
    txn(0, 1, 2'd1, 0, 32'h32, 32'hFFFF_1234, 32'h210, 0, 32'h0, 0);
    txn(1, 0, 2'd2, 0, 32'h30, 32'h0, 32'h214, 0, 32'h1234_ABDE, 0);
    txn(1, 0, 2'd0, 0, 32'h33, 32'h0, 32'h218, 0, 32'h0000_0012, 0);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory stage. Sits directly downstream of the EX/MEM pipeline register.
- Consumes the register's memory-op flags, the computed address/result and the PC tag.
- Performs load/store to an internal word-organised data memory and emits a completion (result + PC tag) toward writeback/ROB.
- Non-memory ops pass through with their EX result.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in data memory; power of 2.
- ADDR_W, 32, address/data-path width of addr input.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  1  request present from EX/MEM register
- req_ready  out  1  LSU can accept a request this cycle
- op_read  in  1  load
- op_write  in  1  store
- size  in  2  0=byte, 1=half, 2=word, 3=reserved
- load_unsigned  in  1  zero-extend loads when 1, sign-extend when 0
- addr  in  32  effective address (EX result for non-memory ops)
- wdata  in  32  store data (low bytes used for byte/half)
- pc_in  in  32  PC tag of the instruction
- resp_valid  out  1  completion valid
- resp_ready  in  1  consumer accepts completion
- resp_data  out  32  load data / passthrough result / 0 for stores
- resp_pc  out  32  PC tag of completed instruction
- resp_err  out  1  misaligned or illegal op

Behaviour:
- Reset: rstn sampled on rising clk only. State=IDLE. All outputs 0: req_ready, resp_valid, resp_data, resp_pc, resp_err. Memory contents are not reset.
- FSM states: IDLE, LOAD_RD, RESP.
- req_ready = 1 only in IDLE. A request is accepted on a cycle with req_valid & req_ready.
- Memory index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0; size=3 with a memory op.
- Illegal: op_read & op_write both 1.
- On accept in IDLE:
  - Error (misaligned/illegal): no memory access. Go to RESP with resp_err=1, resp_data=0.
  - Neither op: go to RESP with resp_data=addr, resp_err=0.
  - Store: byte-lane write to memory on this clock edge. Byte lane = addr[1:0]; half lane = addr[1]. Go to RESP with resp_data=0.
  - Load: capture index, size, unsigned flag and lane, then go to LOAD_RD.
- LOAD_RD: synchronous memory read completes. Extract lane, extend to 32 bits, go to RESP.
- RESP: resp_valid=1 and all resp_* held stable until resp_valid & resp_ready, then go to IDLE. No new request is accepted until the cycle after the handshake.
- Latency from accept edge to resp_valid high: 1 cycle for passthrough, store and error; 2 cycles for load.
- Throughput: at most one request in flight. Back-to-back best case is one request every 2 cycles (passthrough/store) or every 3 cycles (load).
- pc_in is captured on accept and presented as resp_pc.
- Load after store to the same word: the store is already committed at its accept edge, so the load returns the new data.
- Reset asserted mid-operation: return to IDLE next edge. resp_valid drops, any in-flight load is discarded, and memory writes already performed are kept.
- req_valid while not ready: ignored. The upstream must hold its request.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- When defined, add two outputs:
  - load_count, out, 32: +1 per accepted non-error load.
  - store_count, out, 32: +1 per accepted non-error store.
  - Both reset to 0 and wrap at 2^32.
- When undefined: ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Word store then load: store addr=0x10, wdata=0xDEADBEEF, size=2. Then load addr=0x10, size=2. Expect store resp_data=0 one cycle after accept; load resp_data=0xDEADBEEF two cycles after accept; resp_pc matches each request.
- Byte/half extension: store word 0x80FF7F01 at 0x20.
  - Load byte addr 0x22, signed -> 0xFFFFFFFF.
  - Same load, unsigned -> 0x000000FF.
  - Load half addr 0x22, signed -> 0xFFFF80FF.
  - Load byte addr 0x20 -> 0x00000001.
- Errors: half load at 0x21 -> resp_err=1, resp_data=0, memory unchanged. Request with op_read=op_write=1 -> resp_err=1 and no write.
- Passthrough and backpressure: non-memory op with addr=0x12345678 and resp_ready held 0 for 5 cycles. Expect resp_valid, resp_data and resp_pc stable and req_ready=0 throughout; after the handshake, req_ready=1 on the next cycle.
- Wrap and reset: with DEPTH_WORDS=256, store to 0x400 then load from 0x0 -> same data. Assert rstn during LOAD_RD -> next cycle resp_valid=0 and req_ready=1 after release. Counters (if LSU_PERF_CNT_EN) read 0 after reset and 1/1 after one load and one store.
